float_point_add: RTL and testbench

FLOAT_POINT_ADD -- requirements
Module: float_point_add

---
 rtl/float_point_add.sv | 157 +++++++++++++++
 tb/tb_float_point_add.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/float_point_add.sv
// Four-stage IEEE-754 binary32 adder/subtractor: unpack/compare, align, add/sub, normalize/round/pack.
// Round-to-nearest-even; denormal inputs and underflowing results are flushed to signed zero.
module float_point_add (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] iA,
  input  logic [31:0] iB,
  input  logic [1:0]  iOp,
  output logic [31:0] oF,
  output logic        oDone
);

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  logic [4:0]  vld_q;
  logic [31:0] a0_q, b0_q, oF_q, res_d;

  logic        s1_sign_d, s1_sub_d, s1_spec_d, s1_sign_q, s1_sub_q, s1_spec_q;
  logic [7:0]  s1_exp_d, s1_diff_d, s1_exp_q, s1_diff_q;
  logic [23:0] s1_mbig_d, s1_msml_d, s1_mbig_q, s1_msml_q;
  logic [31:0] s1_specv_d, s1_specv_q;

  logic        s2_sign_q, s2_sub_q, s2_spec_q;
  logic [7:0]  s2_exp_q;
  logic [23:0] s2_mbig_q;
  logic [26:0] s2_msml_d, s2_msml_q, s2_full, s2_shift, s2_lost;
  logic [31:0] s2_specv_q;

  logic        s3_sign_q, s3_sub_q, s3_spec_q;
  logic [7:0]  s3_exp_q;
  logic [27:0] s3_sum_d, s3_sum_q;
  logic [31:0] s3_specv_q;

  logic [7:0]  ea, eb;
  logic [22:0] fa, fb;
  logic        a_nan, b_nan, a_inf, b_inf, za, zb, a_big;

  logic [4:0]  lz;
  logic [26:0] m;
  logic [9:0]  e, e2;
  logic [24:0] man;
  logic        rnd;

  function automatic logic [4:0] lzc27(input logic [26:0] v);
    lzc27 = 5'd27;
    for (int i = 0; i < 27; i++)
      if (v[i]) lzc27 = 5'(26 - i);
  endfunction

  // Valid shift register and the output register are the only reset state.
  always_ff @(posedge clk) begin
    if (resetn) begin
      vld_q <= '0;
      oF_q  <= '0;
    end else begin
      vld_q <= {vld_q[3:0], (iOp == 2'b01) || (iOp == 2'b10)};
      if (vld_q[3]) oF_q <= res_d;
    end
  end

  assign oF    = oF_q;
  assign oDone = vld_q[4];

  // Stage 0: capture operands, folding subtraction into B's sign.
  always_ff @(posedge clk) begin
    a0_q <= iA;
    b0_q <= {iB[31] ^ (iOp == 2'b10), iB[30:0]};
  end

  assign ea    = a0_q[30:23];
  assign eb    = b0_q[30:23];
  assign fa    = a0_q[22:0];
  assign fb    = b0_q[22:0];
  assign a_nan = (ea == 8'hFF) && (fa != 23'd0);
  assign b_nan = (eb == 8'hFF) && (fb != 23'd0);
  assign a_inf = (ea == 8'hFF) && (fa == 23'd0);
  assign b_inf = (eb == 8'hFF) && (fb == 23'd0);
  assign za    = (ea == 8'd0);
  assign zb    = (eb == 8'd0);
  assign a_big = (a0_q[30:0] >= b0_q[30:0]);

  // Stage 1: special-operand results bypass the datapath; otherwise order by magnitude.
  always_comb begin
    s1_spec_d  = 1'b1;
    s1_specv_d = QNAN;
    if (a_nan || b_nan || (a_inf && b_inf && (a0_q[31] != b0_q[31]))) s1_specv_d = QNAN;
    else if (a_inf)      s1_specv_d = a0_q;
    else if (b_inf)      s1_specv_d = b0_q;
    else if (za && zb)   s1_specv_d = {a0_q[31] & b0_q[31], 31'd0};
    else if (za)         s1_specv_d = b0_q;
    else if (zb)         s1_specv_d = a0_q;
    else                 s1_spec_d  = 1'b0;
    s1_sub_d = a0_q[31] ^ b0_q[31];
    if (a_big) begin
      s1_sign_d = a0_q[31];
      s1_exp_d  = ea;
      s1_diff_d = ea - eb;
      s1_mbig_d = {1'b1, fa};
      s1_msml_d = {1'b1, fb};
    end else begin
      s1_sign_d = b0_q[31];
      s1_exp_d  = eb;
      s1_diff_d = eb - ea;
      s1_mbig_d = {1'b1, fb};
      s1_msml_d = {1'b1, fa};
    end
  end

  // Stage 2: align small significand with guard/round/sticky.
  always_comb begin
    s2_full  = {s1_msml_q, 3'b000};
    s2_shift = s2_full >> s1_diff_q;
    s2_lost  = s2_full & ~(27'h7FF_FFFF << s1_diff_q);
    if (s1_diff_q > 8'd26) s2_msml_d = 27'd1;
    else                   s2_msml_d = {s2_shift[26:1], s2_shift[0] | (|s2_lost)};
  end

  // Stage 3: big >= small, so subtraction never goes negative.
  assign s3_sum_d = s2_sub_q ? {1'b0, s2_mbig_q, 3'b000} - {1'b0, s2_msml_q}
                             : {1'b0, s2_mbig_q, 3'b000} + {1'b0, s2_msml_q};

  always_ff @(posedge clk) begin
    s1_sign_q <= s1_sign_d;  s1_sub_q  <= s1_sub_d;   s1_spec_q <= s1_spec_d;
    s1_exp_q  <= s1_exp_d;   s1_diff_q <= s1_diff_d;  s1_specv_q <= s1_specv_d;
    s1_mbig_q <= s1_mbig_d;  s1_msml_q <= s1_msml_d;
    s2_sign_q <= s1_sign_q;  s2_sub_q  <= s1_sub_q;   s2_spec_q <= s1_spec_q;
    s2_exp_q  <= s1_exp_q;   s2_mbig_q <= s1_mbig_q;  s2_msml_q <= s2_msml_d;
    s2_specv_q <= s1_specv_q;
    s3_sign_q <= s2_sign_q;  s3_sub_q  <= s2_sub_q;   s3_spec_q <= s2_spec_q;
    s3_exp_q  <= s2_exp_q;   s3_sum_q  <= s3_sum_d;   s3_specv_q <= s2_specv_q;
  end

  // Stage 4: normalize, round to nearest even, pack. Packing adds the rounded
  // significand onto exponent-1 so the hidden bit and any rounding carry land in the exponent.
  assign lz = lzc27(s3_sum_q[26:0]);

  always_comb begin
    m = s3_sum_q[26:0];
    e = {2'b00, s3_exp_q};
    if (s3_sum_q[27]) begin
      m = {s3_sum_q[27:2], s3_sum_q[1] | s3_sum_q[0]};
      e = e + 10'd1;
    end else if (s3_sub_q) begin
      m = s3_sum_q[26:0] << lz;
      e = e - {5'd0, lz};
    end
    rnd = m[2] & (m[1] | m[0] | m[3]);
    man = {1'b0, m[26:3]} + {24'd0, rnd};
    e2  = e + {9'd0, man[24]};
    if (s3_spec_q)                          res_d = s3_specv_q;
    else if (s3_sub_q && s3_sum_q == 28'd0) res_d = 32'h0000_0000;
    else if ($signed(e2) >= 10'sd255)       res_d = {s3_sign_q, 8'hFF, 23'd0};
    else if ($signed(e2) < 10'sd1)          res_d = {s3_sign_q, 31'd0};
    else res_d = {s3_sign_q, {e[7:0] - 8'd1, 23'd0} + {6'd0, man}};
  end

endmodule

// File: tb/tb_float_point_add.sv
// Directed bench for float_point_add: a real-arithmetic reference model, pinned by literal
// expectations, drives a per-cycle scoreboard of oF/oDone.
module tb_float_point_add;

  logic        clk = 1'b0;
  logic        resetn;
  logic [31:0] iA, iB;
  logic [1:0]  iOp;
  logic [31:0] oF;
  logic        oDone;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  float_point_add dut (
    .clk(clk), .resetn(resetn), .iA(iA), .iB(iB), .iOp(iOp), .oF(oF), .oDone(oDone)
  );

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, got, expv);
    end
  endtask

  function automatic real pow2(input int n);
    real r = 1.0;
    if (n >= 0) for (int i = 0; i < n; i++) r = r * 2.0;
    else        for (int i = 0; i < -n; i++) r = r / 2.0;
    return r;
  endfunction

  function automatic real f2r(input logic [31:0] x);
    real mag;
    mag = real'(8388608 + int'(x[22:0])) * pow2(int'(x[30:23]) - 150);
    return x[31] ? -mag : mag;
  endfunction

  // Round an exact real to binary32, nearest-even, flushing tiny results.
  function automatic logic [31:0] r2f(input real r);
    logic   s;
    real    x, mr, fr;
    int     e, be;
    longint mi;
    if (r == 0.0) return 32'h0;
    s = (r < 0.0);
    x = s ? -r : r;
    e = 0;
    while (x >= 2.0) begin x = x / 2.0; e++; end
    while (x < 1.0)  begin x = x * 2.0; e--; end
    mr = x * 8388608.0;
    mi = longint'($floor(mr));
    fr = mr - $floor(mr);
    if (fr > 0.5 || (fr == 0.5 && mi[0])) mi++;
    if (mi == 64'd16777216) begin mi = 64'd8388608; e++; end
    be = e + 127;
    if (be >= 255) return {s, 8'hFF, 23'd0};
    if (be < 1)    return {s, 31'd0};
    return {s, be[7:0], mi[22:0]};
  endfunction

  function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] bi, input logic [1:0] op);
    logic [31:0] b;
    logic an, bn, ainf, binf, az, bz;
    b = bi;
    if (op == 2'b10) b[31] = ~b[31];
    an   = (a[30:23] == 8'hFF) && (a[22:0] != 0);
    bn   = (b[30:23] == 8'hFF) && (b[22:0] != 0);
    ainf = (a[30:23] == 8'hFF) && (a[22:0] == 0);
    binf = (b[30:23] == 8'hFF) && (b[22:0] == 0);
    az   = (a[30:23] == 8'h00);
    bz   = (b[30:23] == 8'h00);
    if (an || bn || (ainf && binf && a[31] != b[31])) return 32'h7FC00000;
    if (ainf) return a;
    if (binf) return b;
    if (az && bz) return {a[31] & b[31], 31'd0};
    if (az) return b;
    if (bz) return a;
    return r2f(f2r(a) + f2r(b));
  endfunction

  // Scoreboard: results keyed by the cycle they must appear on.
  logic [31:0] due [int];
  logic [31:0] last = 32'h0;
  logic        armed = 1'b0;
  logic        exp_done;
  int          cyc = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
    if (resetn === 1'b1) begin
      due.delete();
      last  = 32'h0;
      armed = 1'b1;
    end else if (armed && (iOp == 2'b01 || iOp == 2'b10)) begin
      due[cyc + 4] = model(iA, iB, iOp);
    end
    #1;
    if (armed) begin
      exp_done = due.exists(cyc);
      if (exp_done) begin
        last = due[cyc];
        due.delete(cyc);
      end
      chk("oDone", {31'd0, oDone}, {31'd0, exp_done});
      chk("oF", oF, last);
    end
  end

  // Pin the model with a literal, then issue the same vector to the DUT.
  task automatic vec(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op, input logic [31:0] expv);
    chk("model", model(a, b, op), expv);
    @(negedge clk);
    iA = a; iB = b; iOp = op;
  endtask

  task automatic idle(input int n, input logic [1:0] op);
    repeat (n) begin
      @(negedge clk);
      iA = 32'h40490FDB; iB = 32'h3F800000; iOp = op;
    end
  endtask

  initial begin
    resetn = 1'b1; iA = '0; iB = '0; iOp = 2'b00;
    repeat (2) @(negedge clk);
    resetn = 1'b0;
    @(posedge clk); #1;
    chk("reset_oF", oF, 32'h0);
    chk("reset_oDone", {31'd0, oDone}, 32'd0);

    vec(32'h41480000, 32'h41080000, 2'b01, 32'h41A80000);
    idle(6, 2'b00);
    vec(32'h3FE00000, 32'h3FA80000, 2'b01, 32'h40440000);
    vec(32'h3FE00000, 32'h3FA80000, 2'b10, 32'h3EE00000);
    idle(6, 2'b00);

    vec(32'h7F7FFFFF, 32'h7F7FFFFF, 2'b01, 32'h7F800000);
    vec(32'h7F800000, 32'hFF800000, 2'b01, 32'h7FC00000);
    vec(32'h3F800000, 32'h3F800000, 2'b10, 32'h00000000);
    vec(32'h3F800000, 32'h33800000, 2'b01, 32'h3F800000);
    vec(32'h3F800001, 32'h33800000, 2'b01, 32'h3F800002);
    vec(32'h40000000, 32'h3F800001, 2'b10, 32'h3F7FFFFE);
    vec(32'h4B000000, 32'h3F000000, 2'b01, 32'h4B000000);
    vec(32'h4B000000, 32'h3F000001, 2'b01, 32'h4B000001);
    vec(32'h4B000000, 32'h33800000, 2'b01, 32'h4B000000);
    vec(32'hC0000000, 32'h3F800000, 2'b01, 32'hBF800000);
    vec(32'h00800001, 32'h00800000, 2'b10, 32'h00000000);
    vec(32'h80000000, 32'h80000000, 2'b01, 32'h80000000);
    vec(32'h80000000, 32'h00000000, 2'b01, 32'h00000000);
    vec(32'h00000000, 32'hC1480000, 2'b01, 32'hC1480000);
    vec(32'h00000000, 32'h3F800000, 2'b10, 32'hBF800000);
    vec(32'h00000001, 32'h3F800000, 2'b01, 32'h3F800000);
    vec(32'h7F800000, 32'h3F800000, 2'b01, 32'h7F800000);
    vec(32'h3F800000, 32'h7F800000, 2'b10, 32'hFF800000);
    vec(32'h7FC00001, 32'h3F800000, 2'b01, 32'h7FC00000);
    vec(32'h7F800000, 32'h7F800000, 2'b10, 32'h7FC00000);
    vec(32'hFF800000, 32'hFF800000, 2'b01, 32'hFF800000);
    vec(32'h41480000, 32'h41080000, 2'b10, 32'h40800000);
    idle(6, 2'b00);
    chk("hold_after_stream", oF, 32'h40800000);

    idle(4, 2'b11);
    idle(2, 2'b00);
    chk("hold_after_nop", oF, 32'h40800000);

    vec(32'h41480000, 32'h41080000, 2'b01, 32'h41A80000);
    idle(1, 2'b00);
    @(negedge clk);
    resetn = 1'b1;
    iA = 32'h3F800000; iB = 32'h3F800000; iOp = 2'b01;
    @(negedge clk);
    resetn = 1'b0;
    iOp = 2'b00;
    idle(8, 2'b00);
    chk("flush_oF", oF, 32'h0);
    chk("flush_oDone", {31'd0, oDone}, 32'd0);

    vec(32'h41480000, 32'h41080000, 2'b01, 32'h41A80000);
    idle(6, 2'b00);
    chk("after_reset_op", oF, 32'h41A80000);
    chk("scoreboard_empty", due.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
